regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of the write-back path and register file.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (index width 5).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports alu_valid in 1, alu_rd in 5, alu_data in XLEN, alu_ready out 1: the ALU write-back request channel.
REQ-006 SHALL have ports mem_valid in 1, mem_rd in 5, mem_data in XLEN, mem_ready out 1: the load-unit write-back request channel.
REQ-007 SHALL have ports iss_valid in 1, iss_rd in 5: an issued instruction marks rd as pending.
REQ-008 SHALL have ports rs1 in 5, rs2 in 5, hazard out 1: the read-hazard query.
REQ-009 SHALL have ports rf_we out 1, rf_rd out 5, rf_wdata out XLEN: drive the register-file write port (reg_write, rd, write_data).

Function
REQ-010 SHALL grant at most one requester per cycle; x_ready is combinational and is high only for the granted channel.
REQ-011 SHALL complete a transfer on the cycle x_valid && x_ready; the requester holds valid, rd and data stable until that cycle.
REQ-012 SHALL grant the only valid requester when exactly one is valid, and neither when none is valid.
REQ-013 SHALL register the transferred rd/data: rf_we=1, rf_rd, rf_wdata appear exactly 1 cycle after the transfer cycle (latency 1) for one cycle.
REQ-014 SHALL accept a transfer with rd=0 (ready asserted) but keep rf_we=0 on the following cycle.
REQ-015 SHALL keep rf_we=0 in any cycle that does not follow a transfer; rf_rd/rf_wdata hold their last value.
REQ-016 SHALL keep a NREG-bit pending scoreboard; iss_valid with iss_rd!=0 sets pend[iss_rd] at the clock edge.
REQ-017 SHALL clear pend[rf_rd] at the edge where rf_we=1, i.e. the same edge on which the register file captures the data.
REQ-018 SHALL let set win when an issue and a clear target the same register on the same edge.
REQ-019 SHALL treat a write to a non-pending register as legal; no state change other than the RF write.
REQ-020 SHALL drive hazard = pend[rs1] | pend[rs2], combinationally; pend[0] is constant 0.
REQ-021 SHALL ignore iss_valid with iss_rd=0.

Reset
REQ-022 SHALL on rst_n=0 at a clock edge clear pend to all zeros, clear rf_we, rf_rd and rf_wdata to 0, and set last_grant=MEM.
REQ-023 SHALL hold alu_ready=mem_ready=0 while rst_n=0; no transfer completes and a request pending across reset must be re-presented.
REQ-024 SHALL drop a write staged in the output register when reset is asserted mid-operation; it never reaches the RF.

Configuration
REQ-025 SHALL use macro WB_RR_ARB_EN to select the arbitration policy.
REQ-026 SHALL, when WB_RR_ARB_EN is defined, resolve a tie round-robin: grant the channel not in last_grant; last_grant updates to the granted channel on every transfer.
REQ-027 SHALL, when WB_RR_ARB_EN is undefined, resolve a tie with fixed priority: MEM always wins, the last_grant register is absent, and ALU may starve.

Verification
REQ-028 SHALL cover single ALU write: alu_valid, rd=5, data=0xDEADBEEF -> alu_ready same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; following cycle rf_we=0.
REQ-029 SHALL cover tie under WB_RR_ARB_EN after reset: both valid (alu rd=1, mem rd=2) held -> ALU granted first, MEM second; RF writes rd=1 then rd=2 on consecutive cycles. Undefined -> MEM first.
REQ-030 SHALL cover scoreboard: issue rd=7, then rs1=7 -> hazard=1; MEM writes rd=7 -> hazard stays 1 through the rf_we cycle and reads 0 the cycle after.
REQ-031 SHALL cover simultaneous issue rd=9 and rf_we with rf_rd=9 -> pend[9] remains 1 and hazard for rs2=9 stays 1.
REQ-032 SHALL cover x0: issue rd=0 and an ALU transfer with rd=0 -> hazard for rs1=0 stays 0, alu_ready=1, and rf_we remains 0.
REQ-033 SHALL cover reset mid-operation: transfer rd=3, then rst_n=0 on the next edge -> rf_we=0 and hazard=0 for all registers.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wb_arbiter: ALU/MEM write-back arbiter + pending-register table  |
// | Tie policy: WB_RR_ARB_EN defined -> round-robin, else MEM fixed priority |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            hazard,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata
);

    logic            w_grant_alu;
    logic            w_grant_mem;
    logic            w_xfer;
    logic [4:0]      w_xfer_rd;
    logic [XLEN-1:0] w_xfer_data;

    logic            rf_we_q,    rf_we_d;
    logic [4:0]      rf_rd_q,    rf_rd_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0] pend_q,     pend_d;

    function automatic logic pend_at(input logic [NREG-1:0] v, input logic [4:0] idx);
        pend_at = (int'(idx) < NREG) ? v[idx] : 1'b0;
    endfunction

`ifdef WB_RR_ARB_EN
    localparam logic c_sel_alu = 1'b0;
    localparam logic c_sel_mem = 1'b1;

    logic last_grant_q, last_grant_d;

    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        if (rst_n) begin
            if (alu_valid && mem_valid) begin
                // On a tie the channel that did not win last time goes first.
                if (last_grant_q == c_sel_mem) begin
                    w_grant_alu = 1'b1;
                end else begin
                    w_grant_mem = 1'b1;
                end
            end else begin
                w_grant_alu = alu_valid;
                w_grant_mem = mem_valid;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (w_grant_mem) begin
            last_grant_d = c_sel_mem;
        end else if (w_grant_alu) begin
            last_grant_d = c_sel_alu;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= c_sel_mem;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        if (rst_n) begin
            w_grant_mem = mem_valid;
            w_grant_alu = alu_valid && !mem_valid;
        end
    end
`endif

    assign alu_ready   = w_grant_alu;
    assign mem_ready   = w_grant_mem;
    assign w_xfer      = w_grant_alu || w_grant_mem;
    assign w_xfer_rd   = w_grant_mem ? mem_rd   : alu_rd;
    assign w_xfer_data = w_grant_mem ? mem_data : alu_data;

    // Writes to x0 are accepted on the channel but never reach the RF.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (w_xfer) begin
            rf_we_d    = (w_xfer_rd != 5'd0);
            rf_rd_d    = w_xfer_rd;
            rf_wdata_d = w_xfer_data;
        end
    end

    // Clear first, then set, so a same-edge issue keeps the register pending.
    always_comb begin
        pend_d = pend_q;
        if (rf_we_q && (int'(rf_rd_q) < NREG)) begin
            pend_d[rf_rd_q] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0) && (int'(iss_rd) < NREG)) begin
            pend_d[iss_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= '0;
            pend_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            pend_q     <= pend_d;
        end
    end

    assign hazard   = pend_at(pend_q, rs1) | pend_at(pend_q, rs2);
    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_wb_arbiter: directed + randomized bench for regfile_wb_arbiter|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

`ifdef WB_RR_ARB_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        alu_valid, mem_valid, iss_valid;
    logic [4:0]  alu_rd, mem_rd, iss_rd, rs1, rs2;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, hazard, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    int n_checks;
    int n_err;

    // Reference model state
    bit          pend_m [32];
    bit          last_mem_m;
    bit          exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rs1(rs1), .rs2(rs2), .hazard(hazard),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
        alu_rd = '0; mem_rd = '0; iss_rd = '0;
        alu_data = '0; mem_data = '0;
        rs1 = '0; rs2 = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        foreach (pend_m[i]) pend_m[i] = 1'b0;
        last_mem_m = 1'b1;
        exp_we     = 1'b0;
    endtask

    initial begin
        bit          ga, gm, a_first;
        logic [4:0]  first_rd, second_rd;
        n_checks = 0;
        n_err    = 0;
        idle();

        // Reset: requests present while in reset must not be granted
        rst_n = 1'b0;
        alu_valid = 1'b1; mem_valid = 1'b1; alu_rd = 5'd4; mem_rd = 5'd6;
        tick();
        #1;
        chk("reset_alu_ready", alu_ready, 0);
        chk("reset_mem_ready", mem_ready, 0);
        tick();
        chk("reset_rf_we", rf_we, 0);
        chk("reset_rf_rd", rf_rd, 0);
        chk("reset_rf_wdata", rf_wdata, 0);
        rs1 = 5'd4; rs2 = 5'd6; #1;
        chk("reset_hazard", hazard, 0);
        idle();
        rst_n = 1'b1;
        tick();

        // Single ALU write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; #1;
        chk("alu_single_ready", alu_ready, 1);
        chk("alu_single_mem_ready", mem_ready, 0);
        tick();
        alu_valid = 1'b0;
        chk("alu_single_we", rf_we, 1);
        chk("alu_single_rd", rf_rd, 5);
        chk("alu_single_data", rf_wdata, 32'hDEADBEEF);
        tick();
        chk("alu_single_we_off", rf_we, 0);
        chk("alu_single_rd_hold", rf_rd, 5);
        chk("alu_single_data_hold", rf_wdata, 32'hDEADBEEF);

        // Tie immediately after reset
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1A1A1A1;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hB2B2B2B2; #1;
        a_first   = RR_MODE;
        first_rd  = a_first ? 5'd1 : 5'd2;
        second_rd = a_first ? 5'd2 : 5'd1;
        chk("tie_first_alu_ready", alu_ready, a_first);
        chk("tie_first_mem_ready", mem_ready, !a_first);
        tick();
        if (a_first) alu_valid = 1'b0; else mem_valid = 1'b0;
        #1;
        chk("tie_second_alu_ready", alu_ready, !a_first);
        chk("tie_second_mem_ready", mem_ready, a_first);
        chk("tie_first_we", rf_we, 1);
        chk("tie_first_rd", rf_rd, first_rd);
        tick();
        idle();
        chk("tie_second_we", rf_we, 1);
        chk("tie_second_rd", rf_rd, second_rd);
        chk("tie_second_data", rf_wdata, a_first ? 32'hB2B2B2B2 : 32'hA1A1A1A1);
        tick();
        chk("tie_done_we", rf_we, 0);

        // Scoreboard set / clear timing
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0; rs1 = 5'd7; #1;
        chk("sb_hazard_set", hazard, 1);
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h00000777; #1;
        chk("sb_mem_ready", mem_ready, 1);
        tick();
        mem_valid = 1'b0; #1;
        chk("sb_we_cycle", rf_we, 1);
        chk("sb_hazard_we_cycle", hazard, 1);
        tick();
        chk("sb_hazard_cleared", hazard, 0);
        chk("sb_we_off", rf_we, 0);

        // Issue and clear of the same register on the same edge
        rs1 = 5'd0;
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0; rs2 = 5'd9; #1;
        chk("sw_hazard_set", hazard, 1);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99; #1;
        chk("sw_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd9; #1;
        chk("sw_we", rf_we, 1);
        chk("sw_rd", rf_rd, 9);
        tick();
        iss_valid = 1'b0; #1;
        chk("sw_hazard_kept", hazard, 1);
        tick();
        chk("sw_hazard_kept2", hazard, 1);

        // x0: issue and write-back of register 0
        rs1 = 5'd0; rs2 = 5'd0;
        iss_valid = 1'b1; iss_rd = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55; #1;
        chk("x0_alu_ready", alu_ready, 1);
        chk("x0_hazard_pre", hazard, 0);
        tick();
        idle(); #1;
        chk("x0_we", rf_we, 0);
        chk("x0_hazard", hazard, 0);
        tick();
        chk("x0_we_next", rf_we, 0);

        // Reset while a write is staged
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33333333;
        tick();
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        rst_n = 1'b0; #1;
        chk("rm_staged_we", rf_we, 1);
        chk("rm_alu_ready_in_reset", alu_ready, 0);
        tick();
        chk("rm_we", rf_we, 0);
        chk("rm_rf_rd", rf_rd, 0);
        chk("rm_rf_wdata", rf_wdata, 0);
        for (int r = 0; r < 32; r++) begin
            rs1 = r[4:0]; rs2 = r[4:0]; #1;
            chk("rm_hazard", hazard, 0);
        end
        tick();
        chk("rm_we_hold", rf_we, 0);
        idle();
        rst_n = 1'b1;
        tick();

        // Randomized traffic against the reference model
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!alu_valid && ($urandom_range(0, 1) == 1)) begin
                alu_valid = 1'b1;
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!mem_valid && ($urandom_range(0, 1) == 1)) begin
                mem_valid = 1'b1;
                mem_rd    = 5'($urandom_range(0, 31));
                mem_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_rd    = 5'($urandom_range(0, 31));
            rs1       = 5'($urandom_range(0, 31));
            rs2       = 5'($urandom_range(0, 31));
            #1;

            if (alu_valid && mem_valid) begin
                gm = RR_MODE ? !last_mem_m : 1'b1;
                ga = !gm;
            end else begin
                ga = alu_valid;
                gm = mem_valid;
            end
            chk("rnd_alu_ready", alu_ready, ga);
            chk("rnd_mem_ready", mem_ready, gm);
            chk("rnd_hazard", hazard, pend_m[rs1] | pend_m[rs2]);
            chk("rnd_rf_we", rf_we, exp_we);
            if (exp_we) begin
                chk("rnd_rf_rd", rf_rd, exp_rd);
                chk("rnd_rf_wdata", rf_wdata, exp_data);
            end

            if (exp_we) pend_m[exp_rd] = 1'b0;
            if (iss_valid && iss_rd != 0) pend_m[iss_rd] = 1'b1;
            if (ga || gm) begin
                last_mem_m = gm;
                exp_rd     = gm ? mem_rd : alu_rd;
                exp_data   = gm ? mem_data : alu_data;
                exp_we     = (exp_rd != 0);
            end else begin
                exp_we = 1'b0;
            end

            tick();
            if (ga) alu_valid = 1'b0;
            if (gm) mem_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
